// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the oversampling UART receiver with FIFO.
// Holds parity modes, the receive FSM state type and the divider helper.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PAR,
      S_STOP,
      S_WAIT_HI
   } state_e;

   // Rounded clocks-per-sample-tick divider.
   function automatic int uart_div(
      input int clk_freq,
      input int baud,
      input int os
   );
      return (clk_freq + (baud * os) / 2) / (baud * os);
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; head entry visible while non-empty.
// Ports: push/wdata write, pop read, rdata head (0 when empty), full/empty/count.
module uart_sync_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wdata,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wp_q;
   logic [AW-1:0]    rp_q;
   logic [AW:0]      cnt_q;
   logic             do_push;
   logic             do_pop;

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == (AW+1)'(DEPTH));

   // A pop frees the slot, so a push into a full FIFO still lands.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wp_q <= wp_q + 1'b1;
         if (do_pop)  rp_q <= rp_q + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wp_q] <= wdata;
   end

   assign rdata = empty ? '0 : mem_q[rp_q];
   assign count = cnt_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver (majority vote, parity, 1/2 stop) feeding a FWFT FIFO.
// Ports: rx serial in; rd_en/rd_data/rd_perr/rd_ferr/rd_valid/fifo_count drain side;
// rx_done frame pulse; overrun sticky drop flag cleared by clr_ovr.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115_200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = PAR_NONE,
   parameter int STOP_BITS  = 1,
   parameter int OVERSAMPLE = 16,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        rx,
   input  logic                        rd_en,
   input  logic                        clr_ovr,
   output logic [DATA_BITS-1:0]        rd_data,
   output logic                        rd_perr,
   output logic                        rd_ferr,
   output logic                        rd_valid,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        rx_done,
   output logic                        overrun
);

   localparam int DIV = uart_div(CLK_FREQ, BAUD, OVERSAMPLE);
   localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int SW  = $clog2(OVERSAMPLE);
   localparam int BW  = $clog2(DATA_BITS);
   localparam int M   = OVERSAMPLE / 2;
   localparam int FW  = DATA_BITS + 2;

   logic [1:0]           sync_q;
   logic [1:0]           arm_q;
   logic                 prev_q;
   state_e               state_q, state_d;
   logic [DW-1:0]        div_q, div_d;
   logic [SW-1:0]        os_q, os_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] sh_q, sh_d;
   logic [1:0]           smp_q, smp_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic                 stop_q, stop_d;
   logic                 done_q;
   logic                 ovr_q, ovr_d;

   logic                 rx_s;
   logic                 tick;
   logic                 vote_t;
   logic                 vote;
   logic                 fall;
   logic                 push;
   logic [FW-1:0]        wdata;
   logic [FW-1:0]        head;
   logic                 full;
   logic                 empty;

   assign rx_s   = sync_q[1];
   assign tick   = (div_q == DW'(DIV - 1));
   assign vote_t = tick && (os_q == SW'(M + 1));
   assign vote   = (smp_q[0] & smp_q[1]) |
                   (smp_q[0] & rx_s) |
                   (smp_q[1] & rx_s);
   // prev_q only carries real line samples once the reset value of the
   // synchroniser has flushed, so a line already low at reset release
   // is not mistaken for a start edge.
   assign fall   = prev_q & ~rx_s;

   always_comb begin
      state_d = state_q;
      div_d   = tick ? '0 : div_q + 1'b1;
      os_d    = os_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      smp_d   = smp_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      stop_d  = stop_q;
      push    = 1'b0;
      wdata   = {ferr_q, perr_q, sh_q};

      if (tick) begin
         os_d = (os_q == SW'(OVERSAMPLE - 1)) ? '0 : os_q + 1'b1;
         if (os_q == SW'(M - 1)) smp_d[0] = rx_s;
         if (os_q == SW'(M))     smp_d[1] = rx_s;
      end

      unique case (state_q)
         S_IDLE: begin
            if (fall) begin
               state_d = S_START;
               div_d   = '0;
               os_d    = '0;
               bit_d   = '0;
               perr_d  = 1'b0;
               ferr_d  = 1'b0;
               stop_d  = 1'b0;
            end
         end
         S_START: begin
            if (vote_t) state_d = vote ? S_IDLE : S_DATA;
         end
         S_DATA: begin
            if (vote_t) begin
               sh_d  = {vote, sh_q[DATA_BITS-1:1]};
               bit_d = bit_q + 1'b1;
               if (bit_q == BW'(DATA_BITS - 1))
                  state_d = (PARITY != PAR_NONE) ? S_PAR : S_STOP;
            end
         end
         S_PAR: begin
            if (vote_t) begin
               perr_d  = ((^sh_q) ^ vote) != (PARITY == PAR_ODD);
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (vote_t) begin
               ferr_d = ferr_q | ~vote;
               if (STOP_BITS == 1 || stop_q) begin
                  push    = 1'b1;
                  wdata   = {ferr_d, perr_q, sh_q};
                  // A low line here is a break; wait for it to release.
                  state_d = rx_s ? S_IDLE : S_WAIT_HI;
               end else begin
                  stop_d = 1'b1;
               end
            end
         end
         S_WAIT_HI: begin
            if (rx_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Overrun wins over a same-cycle clear.
   assign ovr_d = (push & full & ~rd_en) | (ovr_q & ~clr_ovr);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q  <= 2'b11;
         arm_q   <= 2'b00;
         prev_q  <= 1'b0;
         state_q <= S_IDLE;
         div_q   <= '0;
         os_q    <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         smp_q   <= '0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         stop_q  <= 1'b0;
         done_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], rx};
         arm_q   <= {arm_q[0], 1'b1};
         prev_q  <= rx_s & arm_q[1];
         state_q <= state_d;
         div_q   <= div_d;
         os_q    <= os_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         smp_q   <= smp_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         stop_q  <= stop_d;
         done_q  <= push;
         ovr_q   <= ovr_d;
      end
   end

   uart_sync_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (wdata),
      .pop   (rd_en),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

   assign rd_data  = head[DATA_BITS-1:0];
   assign rd_perr  = head[DATA_BITS];
   assign rd_ferr  = head[DATA_BITS+1];
   assign rd_valid = ~empty;
   assign rx_done  = done_q;
   assign overrun  = ovr_q;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver, next generation of the fixed 8N1 receiver. Samples the serial line at OVERSAMPLE× baud with majority voting. Supports configurable data width, parity and stop bits, and flags framing, parity and overrun errors. Received words go into an on-chip first-word-fall-through FIFO, so host logic can drain bytes at its own pace.

## Interface
- CLK_FREQ, 50_000_000: clock frequency in Hz.
- BAUD, 115200: line rate in baud.
- DATA_BITS, 8: data bits per frame, 5–9.
- PARITY, 0: 0 none, 1 odd, 2 even.
- STOP_BITS, 1: 1 or 2.
- OVERSAMPLE, 16: samples per bit, even, ≥8.
- FIFO_DEPTH, 16: FIFO entries, power of two, ≥2.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  serial input, idle high, asynchronous to clk.
- rd_en  in  1  pop head entry; ignored when rd_valid=0.
- clr_ovr  in  1  clears the sticky overrun flag.
- rd_data  out  DATA_BITS  head-of-FIFO data, valid while rd_valid=1.
- rd_perr  out  1  parity error of head entry (0 when PARITY=0).
- rd_ferr  out  1  framing error of head entry.
- rd_valid  out  1  FIFO non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy.
- rx_done  out  1  one-cycle pulse per completed frame, including frames that are dropped.
- overrun  out  1  sticky; a frame was dropped because the FIFO was full.

## Operation
- Input path: rx passes through a 2-flop synchroniser; the core sees rx_s.
- Tick generator: DIV = round(CLK_FREQ/(BAUD*OVERSAMPLE)); a counter produces a one-cycle tick every DIV clocks. Counter restarts on start-edge detect so sample phase aligns with the frame.
- Bit phase: a sample counter runs 0..OVERSAMPLE-1 per bit. Bit value = majority of samples at M-1, M, M+1, where M = OVERSAMPLE/2.
- FSM states: IDLE, START, DATA, PAR, STOP, WAIT_HI.
  - IDLE → START: on rx_s falling edge.
  - START → IDLE: start-bit vote = 1 (glitch reject; no write, no rx_done).
  - START → DATA: start-bit vote = 0.
  - DATA: shifts DATA_BITS bits LSB first, then → PAR if PARITY≠0, else → STOP.
  - PAR: rd_perr = XOR(data, parity bit) ≠ expected. Expected is 1 for odd, 0 for even.
  - STOP: each stop bit is voted; any 0 sets ferr. At the vote of the last stop bit:
    - write {ferr, perr, data} to the FIFO and pulse rx_done.
    - then → IDLE if rx_s=1, else → WAIT_HI (break / stuck-low line).
  - WAIT_HI → IDLE: rx_s=1. A break therefore yields exactly one entry with data=0 and ferr=1.
- FIFO write when full with no simultaneous pop: entry dropped, overrun←1, rx_done still pulses.
- overrun stays set until a clr_ovr cycle. If clr_ovr and a new overrun occur in the same cycle, overrun stays 1.
- FIFO pop and push in the same cycle: both take effect, fifo_count unchanged. This holds when full, so no overrun is raised.
- Pointers wrap modulo FIFO_DEPTH; fifo_count distinguishes full from empty.

## Timing
- Reset values, all outputs: 0. These are rd_data, rd_perr, rd_ferr, rd_valid, fifo_count, rx_done and overrun. FSM goes to IDLE, tick and sample counters clear, FIFO empties, synchroniser flops go to 1.
- Reset mid-frame discards the partial frame. After reset deasserts, a new frame is accepted only on a fresh falling edge.
- rx → rx_s latency: 2 clocks.
- rx_done asserts on the clock after the tick carrying the last stop-bit centre sample.
- The FIFO write takes place on that same clock edge.
- rd_valid, rd_data and fifo_count reflect the new entry on the following clock (FWFT, registered).
- Pop: rd_en=1 with rd_valid=1 at edge N. The next entry, or rd_valid=0, is presented after edge N.
- Minimum frame spacing accepted: zero idle bits. The next start edge is detected from the cycle after the STOP → IDLE transition.

## Structure
- Package uart_pkg holds:
  - parity mode constants PAR_NONE/PAR_ODD/PAR_EVEN.
  - the FSM state enum.
  - function uart_div(clk_freq, baud, os) returning the rounded divider.
- Sub-module uart_sync_fifo: parameters WIDTH and DEPTH; FWFT; push/pop/full/empty/count. Instantiated with WIDTH = DATA_BITS+2.
- Top level holds the synchroniser, tick generator, FSM and error logic.

## Test plan
Defaults are 50 MHz / 115200 / 16×, so DIV=27 and one bit = 432 clocks.
- 8N1, send 0xA5 → one rx_done. rd_valid=1 with rd_data=0xA5, perr=0, ferr=0, fifo_count=1. rd_en pulse → rd_valid=0.
- PARITY=2, send 0x37 with correct even parity bit (1), then 0x37 with parity bit 0 → entries (0x37, perr=0) then (0x37, perr=1).
- Stop bit forced low on 0x55 → rd_ferr=1. Hold rx low for 3 frame times → exactly one entry (0x00, ferr=1); FSM returns to IDLE only after rx goes high.
- 300 ns low glitch on idle rx → no rx_done, fifo_count stays 0.
- FIFO_DEPTH=4, send 5 frames without reading → fifo_count=4, overrun=1, head=first byte. clr_ovr → overrun=0.
- Reset mid-data-bit of a frame, then send 0x3C → only 0x3C received. DATA_BITS=9 with STOP_BITS=2, send 0x1FF → rd_data=0x1FF.
